vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_if.sv | 12 +
 rtl/vga_timing.sv | 54 +++++
 tb/tb_vga_timing.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 800x600@60 timing constants shared by the VGA pipeline, plus a window-decode helper.
package vga_pkg;
   localparam logic [10:0] HOR_TOTAL       = 11'd1056;
   localparam logic [10:0] HOR_BLANK_START = 11'd800;
   localparam logic [10:0] HOR_SYNC_START  = 11'd840;
   localparam logic [10:0] HOR_SYNC_STOP   = 11'd968;
   localparam logic [10:0] VER_TOTAL       = 11'd628;
   localparam logic [10:0] VER_BLANK_START = 11'd600;
   localparam logic [10:0] VER_SYNC_START  = 11'd601;
   localparam logic [10:0] VER_SYNC_STOP   = 11'd605;
   localparam logic [10:0] CNT_ONE         = 11'd1;
   localparam logic [10:0] HOR_LAST        = HOR_TOTAL - CNT_ONE;
   localparam logic [10:0] VER_LAST        = VER_TOTAL - CNT_ONE;

   function automatic logic in_win(input logic [10:0] x, input logic [10:0] lo, input logic [10:0] hi);
      return (x >= lo) && (x < hi);
   endfunction
endpackage

// File: rtl/vga_if.sv
// vga_if: VGA stream bundle passed from the timing generator down the draw pipeline.
interface vga_if;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [11:0] rgb;
   modport out (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
   modport in  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: 800x600@60 counters with registered sync/blank decode.
// Optional start-of-frame pulse frame_tick when VGA_TIMING_FRAME_TICK_EN is defined.
module vga_timing
   import vga_pkg::*;
#(
   parameter logic [11:0] RGB_FILL = 12'h0_0_0
) (
   input  logic clk,
   input  logic rst,
`ifdef VGA_TIMING_FRAME_TICK_EN
   output logic frame_tick,
`endif
   vga_if.out   out
);
   logic [10:0] h_q, h_d, v_q, v_d;
   logic        hsync_q, hblnk_q, vsync_q, vblnk_q;
   logic [11:0] rgb_q;
   always_comb begin
      h_d = (h_q == HOR_LAST) ? '0 : h_q + CNT_ONE;
      v_d = (h_q != HOR_LAST) ? v_q : (v_q == VER_LAST) ? '0 : v_q + CNT_ONE;
   end
   // Flags decode the next counter values so they land in the same cycle as the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q     <= '0;
         v_q     <= '0;
         hsync_q <= 1'b0;
         hblnk_q <= 1'b0;
         vsync_q <= 1'b0;
         vblnk_q <= 1'b0;
         rgb_q   <= '0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         hsync_q <= in_win(h_d, HOR_SYNC_START, HOR_SYNC_STOP);
         hblnk_q <= h_d >= HOR_BLANK_START;
         vsync_q <= in_win(v_d, VER_SYNC_START, VER_SYNC_STOP);
         vblnk_q <= v_d >= VER_BLANK_START;
         rgb_q   <= RGB_FILL;
      end
   end
   assign out.hcount = h_q;
   assign out.vcount = v_q;
   assign out.hsync  = hsync_q;
   assign out.hblnk  = hblnk_q;
   assign out.vsync  = vsync_q;
   assign out.vblnk  = vblnk_q;
   assign out.rgb    = rgb_q;
`ifdef VGA_TIMING_FRAME_TICK_EN
   logic tick_q;
   always_ff @(posedge clk) tick_q <= !rst && (h_d == '0) && (v_d == '0);
   assign frame_tick = tick_q;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: pixel-index reference model checked every cycle, plus hand-computed pins.
// Counters are preloaded at negedges to reach line/frame boundaries within a short run.
module tb_vga_timing;
   localparam int HT    = 1056;
   localparam int VT    = 628;
   localparam int FRAME = HT * VT;
   logic clk = 1'b0;
   logic rst = 1'b1;
   vga_if vif ();
`ifdef VGA_TIMING_FRAME_TICK_EN
   logic frame_tick;
`endif
   vga_timing dut (
      .clk(clk),
      .rst(rst),
`ifdef VGA_TIMING_FRAME_TICK_EN
      .frame_tick(frame_tick),
`endif
      .out(vif)
   );
   always #10 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int idx     = 0;
   bit in_rst  = 1'b1;
   bit live    = 1'b0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   task automatic poke(input int h, input int v);
      dut.h_q = h[10:0];
      dut.v_q = v[10:0];
      idx = v * HT + h;
   endtask

   // Model: position = pixel index within the frame; outputs follow from the timing rules.
   initial forever begin
      logic r;
      int h, v;
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
         idx = 0; in_rst = 1'b1; live = 1'b1;
      end else if (live) begin
         idx = (idx + 1) % FRAME; in_rst = 1'b0;
      end
      if (live) begin
         h = idx % HT;
         v = idx / HT;
         chk("hcount", vif.hcount, h);
         chk("vcount", vif.vcount, v);
         chk("hblnk", vif.hblnk, h >= 800);
         chk("hsync", vif.hsync, h >= 840 && h < 968);
         chk("vblnk", vif.vblnk, v >= 600);
         chk("vsync", vif.vsync, v >= 601 && v < 605);
         chk("rgb", vif.rgb, 0);
`ifdef VGA_TIMING_FRAME_TICK_EN
         chk("frame_tick", frame_tick, !in_rst && idx == 0);
`endif
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int hs, hb, vs, first_hb, first_hs, last_hs, first_vb, first_vs, last_vs, ticks;
      repeat (10) @(negedge clk);
      chk("rst_hcount", vif.hcount, 0);
      chk("rst_vcount", vif.vcount, 0);
      chk("rst_hblnk", vif.hblnk, 0);
      chk("rst_rgb", vif.rgb, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("first_hcount", vif.hcount, 1);
      chk("first_vcount", vif.vcount, 0);
      hs = 0; hb = 0; first_hb = -1; first_hs = -1; last_hs = -1;
      for (int i = 0; i < HT; i++) begin
         @(negedge clk);
         hs += int'(vif.hsync);
         hb += int'(vif.hblnk);
         if (vif.hblnk && first_hb < 0) first_hb = int'(vif.hcount);
         if (vif.hsync && first_hs < 0) first_hs = int'(vif.hcount);
         if (vif.hsync) last_hs = int'(vif.hcount);
      end
      chk("hsync_width", hs, 128);
      chk("hblnk_width", hb, 256);
      chk("hblnk_rise", first_hb, 800);
      chk("hsync_first", first_hs, 840);
      chk("hsync_last", last_hs, 967);
      poke(1054, 10);
      @(negedge clk);
      chk("line10_end_h", vif.hcount, 1055);
      chk("line10_end_hblnk", vif.hblnk, 1);
      @(negedge clk);
      chk("line11_h", vif.hcount, 0);
      chk("line11_v", vif.vcount, 11);
      chk("line11_hblnk", vif.hblnk, 0);
      poke(1050, 598);
      vs = 0; first_vb = -1; first_vs = -1; last_vs = -1;
      for (int i = 0; i < 8 * HT; i++) begin
         @(negedge clk);
         vs += int'(vif.vsync);
         if (vif.vblnk && first_vb < 0) first_vb = int'(vif.vcount);
         if (vif.vsync && first_vs < 0) first_vs = int'(vif.vcount);
         if (vif.vsync) last_vs = int'(vif.vcount);
      end
      chk("vsync_clocks", vs, 4 * HT);
      chk("vblnk_rise", first_vb, 600);
      chk("vsync_first", first_vs, 601);
      chk("vsync_last", last_vs, 604);
      poke(1054, 627);
      @(negedge clk);
      chk("frame_end_h", vif.hcount, 1055);
      chk("frame_end_v", vif.vcount, 627);
      @(negedge clk);
      chk("frame_wrap_h", vif.hcount, 0);
      chk("frame_wrap_v", vif.vcount, 0);
      chk("frame_wrap_vblnk", vif.vblnk, 0);
`ifdef VGA_TIMING_FRAME_TICK_EN
      ticks = 0;
      for (int k = 0; k < 2; k++) begin
         poke(1000, 627);
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_tick) begin
               ticks++;
               chk("tick_hcount", vif.hcount, 0);
               chk("tick_vcount", vif.vcount, 0);
            end
         end
      end
      chk("tick_count", ticks, 2);
`else
      ticks = 0;
`endif
      poke(499, 300);
      @(negedge clk);
      chk("mid_h", vif.hcount, 500);
      chk("mid_v", vif.vcount, 300);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_h", vif.hcount, 0);
      chk("mid_rst_v", vif.vcount, 0);
      chk("mid_rst_hsync", vif.hsync, 0);
      chk("mid_rst_vblnk", vif.vblnk, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_h", vif.hcount, 1);
      chk("restart_v", vif.vcount, 0);
      repeat (20) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
